// File: rtl/led_bar_scan_mux.sv
// LED bar multiplexer: picks one of NCH sources for the front-panel bar.
// Display modes are manual select, timed round-robin scan and sticky OR-capture.
module led_bar_scan_mux #(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int SELW   = 2,
  parameter int DWELL  = 25000000,
  parameter bit INVERT = 1'b1
) (
  input  logic                  pll0_25MHz,
  input  logic                  reset,
  input  logic [NCH*WIDTH-1:0]  chData,
  input  logic [SELW-1:0]       sw,
  input  logic                  autoScan,
  input  logic                  stickyMode,
  input  logic                  stickyClr,
  output logic [WIDTH-1:0]      LEDoutData,
  output logic [SELW-1:0]       curChan,
  output logic                  scanTick
);

  localparam int              CW        = $clog2(DWELL);
  localparam logic [SELW-1:0] LAST_CHAN = SELW'(NCH - 1);
  localparam logic [CW-1:0]   DWELL_TC  = CW'(DWELL - 1);

  logic [CW-1:0]    dwell_cnt;
  logic [CW-1:0]    dwell_cnt_next;
  logic [SELW-1:0]  chan_next;
  logic             tick_next;
  logic             chan_change;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] capture_next;
  logic [WIDTH-1:0] disp;
  logic             sticky_prev;

  // Channel selection and dwell timing
  always_comb begin
    chan_next      = curChan;
    dwell_cnt_next = '0;
    tick_next      = 1'b0;
    if (!autoScan) begin
      chan_next = (int'(sw) < NCH) ? sw : LAST_CHAN;
    end else if (dwell_cnt == DWELL_TC) begin
      tick_next = 1'b1;
      chan_next = (curChan == LAST_CHAN) ? '0 : curChan + SELW'(1);
    end else begin
      dwell_cnt_next = dwell_cnt + CW'(1);
    end
  end

  // The sample belongs to the channel being registered at this edge, so the
  // bar and curChan always update together.
  always_comb begin
    sample      = chData[int'(chan_next)*WIDTH +: WIDTH];
    chan_change = (chan_next != curChan);
    if (!stickyMode || !sticky_prev || stickyClr || chan_change) begin
      capture_next = sample;
    end else begin
      capture_next = capture | sample;
    end
    disp = stickyMode ? capture_next : sample;
  end

  always_ff @(posedge pll0_25MHz) begin
    if (reset) begin
      dwell_cnt   <= '0;
      curChan     <= '0;
      scanTick    <= 1'b0;
      capture     <= '0;
      sticky_prev <= 1'b0;
      LEDoutData  <= INVERT ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else begin
      dwell_cnt   <= dwell_cnt_next;
      curChan     <= chan_next;
      scanTick    <= tick_next;
      capture     <= capture_next;
      sticky_prev <= stickyMode;
      LEDoutData  <= INVERT ? ~disp : disp;
    end
  end

endmodule

// File: tb/tb_led_bar_scan_mux.sv
// Directed bench for led_bar_scan_mux: one 4-channel active-low build with a
// short dwell, plus 3-channel builds in both polarities for select saturation.
module tb_led_bar_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ch_a;
  logic [23:0] ch_b;
  logic [1:0]  sw;
  logic        auto_scan;
  logic        sticky_mode;
  logic        sticky_clr;

  logic [7:0]  led_a, led_b, led_c;
  logic [1:0]  chan_a, chan_b, chan_c;
  logic        tick_a, tick_b, tick_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  led_bar_scan_mux #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(4), .INVERT(1'b1)) dut_a (
    .pll0_25MHz(clk), .reset(reset), .chData(ch_a), .sw(sw), .autoScan(auto_scan),
    .stickyMode(sticky_mode), .stickyClr(sticky_clr),
    .LEDoutData(led_a), .curChan(chan_a), .scanTick(tick_a));

  led_bar_scan_mux #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(4), .INVERT(1'b1)) dut_b (
    .pll0_25MHz(clk), .reset(reset), .chData(ch_b), .sw(sw), .autoScan(auto_scan),
    .stickyMode(sticky_mode), .stickyClr(sticky_clr),
    .LEDoutData(led_b), .curChan(chan_b), .scanTick(tick_b));

  led_bar_scan_mux #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(4), .INVERT(1'b0)) dut_c (
    .pll0_25MHz(clk), .reset(reset), .chData(ch_b), .sw(sw), .autoScan(auto_scan),
    .stickyMode(sticky_mode), .stickyClr(sticky_clr),
    .LEDoutData(led_c), .curChan(chan_c), .scanTick(tick_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_a = 32'hDEADBEEF; ch_b = 24'hC0FFEE; sw = 2'd3;
    auto_scan = 1'b1; sticky_mode = 1'b1; sticky_clr = 1'b0;
    step(); step();
    checks++; if (led_a !== 8'hFF) begin fails++; $display("FAIL reset_led_a got %h want ff", led_a); end
    checks++; if (chan_a !== 2'd0) begin fails++; $display("FAIL reset_chan_a got %0d want 0", chan_a); end
    checks++; if (tick_a !== 1'b0) begin fails++; $display("FAIL reset_tick_a got %b want 0", tick_a); end
    checks++; if (led_b !== 8'hFF) begin fails++; $display("FAIL reset_led_b got %h want ff", led_b); end
    checks++; if (led_c !== 8'h00) begin fails++; $display("FAIL reset_led_c got %h want 00", led_c); end
    reset = 1'b0; sw = 2'd2; auto_scan = 1'b0; sticky_mode = 1'b0;
    ch_a = 32'h0000_0000; ch_a[16 +: 8] = 8'h5A;
    step();
    checks++; if (led_a !== 8'hA5) begin fails++; $display("FAIL release_led got %h want a5", led_a); end
    checks++; if (chan_a !== 2'd2) begin fails++; $display("FAIL release_chan got %0d want 2", chan_a); end
  endtask

  task automatic test_out_of_range();
    sw = 2'd3;
    ch_b = 24'h0F_2211;
    ch_a = 32'h3C00_0000;
    step();
    checks++; if (chan_b !== 2'd2) begin fails++; $display("FAIL oor_chan_b got %0d want 2", chan_b); end
    checks++; if (led_b !== 8'hF0) begin fails++; $display("FAIL oor_led_b got %h want f0", led_b); end
    checks++; if (chan_c !== 2'd2) begin fails++; $display("FAIL oor_chan_c got %0d want 2", chan_c); end
    checks++; if (led_c !== 8'h0F) begin fails++; $display("FAIL oor_led_c got %h want 0f", led_c); end
    checks++; if (chan_a !== 2'd3) begin fails++; $display("FAIL inrange_chan_a got %0d want 3", chan_a); end
    checks++; if (led_a !== 8'hC3) begin fails++; $display("FAIL inrange_led_a got %h want c3", led_a); end
  endtask

  task automatic test_auto_scan();
    logic [7:0] chv [4];
    logic [1:0] exp_chan;
    logic       exp_tick;
    chv[0] = 8'h10; chv[1] = 8'h21; chv[2] = 8'h42; chv[3] = 8'h84;
    ch_a = {chv[3], chv[2], chv[1], chv[0]};
    sw = 2'd3; auto_scan = 1'b0;
    step();
    checks++; if (chan_a !== 2'd3) begin fails++; $display("FAIL scan_start_chan got %0d want 3", chan_a); end
    auto_scan = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_chan = 2'((3 + e / 4) % 4);
      exp_tick = (e % 4 == 0);
      checks++;
      if (chan_a !== exp_chan || tick_a !== exp_tick || led_a !== ~chv[exp_chan]) begin
        fails++;
        $display("FAIL scan_edge%0d got chan=%0d tick=%b led=%h want chan=%0d tick=%b led=%h",
                 e, chan_a, tick_a, led_a, exp_chan, exp_tick, ~chv[exp_chan]);
      end
    end
    step(); step();
    auto_scan = 1'b0; sw = 2'd1;
    step();
    checks++; if (chan_a !== 2'd1) begin fails++; $display("FAIL scan_drop_chan got %0d want 1", chan_a); end
    checks++; if (tick_a !== 1'b0) begin fails++; $display("FAIL scan_drop_tick got %b want 0", tick_a); end
    checks++; if (led_a !== 8'hDE) begin fails++; $display("FAIL scan_drop_led got %h want de", led_a); end
  endtask

  task automatic test_sticky_accumulate();
    sw = 2'd0; sticky_mode = 1'b0;
    step();
    sticky_mode = 1'b1; ch_a[7:0] = 8'h01;
    step();
    checks++; if (led_a !== 8'hFE) begin fails++; $display("FAIL sticky_acc1 got %h want fe", led_a); end
    ch_a[7:0] = 8'h10;
    step();
    checks++; if (led_a !== 8'hEE) begin fails++; $display("FAIL sticky_acc2 got %h want ee", led_a); end
    ch_a[7:0] = 8'h80;
    step();
    checks++; if (led_a !== 8'h6E) begin fails++; $display("FAIL sticky_acc3 got %h want 6e", led_a); end
    sticky_clr = 1'b1; ch_a[7:0] = 8'h02;
    step();
    sticky_clr = 1'b0;
    checks++; if (led_a !== 8'hFD) begin fails++; $display("FAIL sticky_clr got %h want fd", led_a); end
  endtask

  task automatic test_sticky_chan_change();
    sticky_clr = 1'b1; ch_a[7:0] = 8'hF0;
    step();
    sticky_clr = 1'b0; ch_a[7:0] = 8'h00;
    step();
    checks++; if (led_a !== 8'h0F) begin fails++; $display("FAIL sticky_hold got %h want 0f", led_a); end
    sw = 2'd1; ch_a[15:8] = 8'h03;
    step();
    checks++; if (led_a !== 8'hFC) begin fails++; $display("FAIL sticky_sw_change got %h want fc", led_a); end
    ch_a[15:8] = 8'hF0; ch_a[23:16] = 8'h03;
    sticky_clr = 1'b1; auto_scan = 1'b1;
    step();
    sticky_clr = 1'b0;
    step(); step();
    checks++; if (led_a !== 8'h0F) begin fails++; $display("FAIL sticky_pre_tick got %h want 0f", led_a); end
    step();
    checks++;
    if (tick_a !== 1'b1 || chan_a !== 2'd2 || led_a !== 8'hFC) begin
      fails++;
      $display("FAIL sticky_tick_change got tick=%b chan=%0d led=%h want tick=1 chan=2 led=fc",
               tick_a, chan_a, led_a);
    end
  endtask

  task automatic test_reset_mid();
    ch_a[23:16] = 8'hFF;
    step(); step();
    reset = 1'b1;
    step();
    checks++;
    if (led_a !== 8'hFF || chan_a !== 2'd0 || tick_a !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got led=%h chan=%0d tick=%b want led=ff chan=0 tick=0",
               led_a, chan_a, tick_a);
    end
    reset = 1'b0; ch_a[7:0] = 8'h01;
    step();
    checks++; if (led_a !== 8'hFE || chan_a !== 2'd0) begin fails++; $display("FAIL mid_rel1 got led=%h chan=%0d want fe 0", led_a, chan_a); end
    ch_a[7:0] = 8'h02;
    step();
    checks++; if (led_a !== 8'hFC || tick_a !== 1'b0) begin fails++; $display("FAIL mid_rel2 got led=%h tick=%b want fc 0", led_a, tick_a); end
    ch_a[7:0] = 8'h04;
    step();
    checks++; if (led_a !== 8'hF8 || chan_a !== 2'd0) begin fails++; $display("FAIL mid_rel3 got led=%h chan=%0d want f8 0", led_a, chan_a); end
    ch_a[15:8] = 8'h55;
    step();
    checks++;
    if (tick_a !== 1'b1 || chan_a !== 2'd1 || led_a !== 8'hAA) begin
      fails++;
      $display("FAIL mid_rel4 got tick=%b chan=%0d led=%h want tick=1 chan=1 led=aa",
               tick_a, chan_a, led_a);
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_auto_scan();
    test_sticky_accumulate();
    test_sticky_chan_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
